// File: rtl/rcs_pkg.sv
// Shared types and defaults for the row candidate sequencer.
// Holds the FSM encoding and the slot index width helper.
package rcs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_EMIT
  } rcs_state_e;

  localparam int RCS_H_W        = 5;
  localparam int RCS_ID_W       = 4;
  localparam int RCS_MAX_CAND   = 3;
  localparam int RCS_MAX_HEIGHT = 16;

  localparam int ID_NONE = 0;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rcs_pick_next.sv
// Lowest-set-bit picker over a slot mask.
// Reports the index, whether any bit is set, and whether others remain.
module rcs_pick_next
  import rcs_pkg::*;
#(
  parameter int N = RCS_MAX_CAND
) (
  input  logic [N-1:0]         mask,
  output logic [slot_w(N)-1:0] idx,
  output logic                 found,
  output logic                 more
);

  localparam int IW = slot_w(N);

  always_comb begin
    idx   = '0;
    found = |mask;
    more  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IW'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (mask[i] && (IW'(i) != idx)) more = 1'b1;
    end
  end

endmodule

// File: rtl/row_candidate_seq.sv
// Height-indexed candidate table with a streaming lookup response.
// Each request emits the nonzero slots of one row, or one "none" beat.
module row_candidate_seq
  import rcs_pkg::*;
#(
  parameter int H_W        = RCS_H_W,
  parameter int ID_W       = RCS_ID_W,
  parameter int MAX_CAND   = RCS_MAX_CAND,
  parameter int MAX_HEIGHT = RCS_MAX_HEIGHT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [H_W-1:0]              req_height,
  output logic                        cand_valid,
  input  logic                        cand_ready,
  output logic [ID_W-1:0]             cand_id,
  output logic                        cand_last,
  output logic                        cand_none,
  input  logic                        cfg_we,
  input  logic [H_W-1:0]              cfg_height,
  input  logic [slot_w(MAX_CAND)-1:0] cfg_slot,
  input  logic [ID_W-1:0]             cfg_id,
  output logic                        busy
);

  localparam int SW = slot_w(MAX_CAND);

  typedef logic [MAX_CAND-1:0][ID_W-1:0] row_t;

  rcs_state_e state_q, state_d;
  logic [H_W-1:0] height_q, height_d;
  row_t snap_q, snap_d;
  logic [MAX_CAND-1:0] rem_q, rem_d;
  logic cand_valid_q, cand_valid_d;
  logic [ID_W-1:0] cand_id_q, cand_id_d;
  logic cand_last_q, cand_last_d;
  logic cand_none_q, cand_none_d;
  row_t tbl_q [MAX_HEIGHT+1];
  row_t tbl_d [MAX_HEIGHT+1];

  row_t row_sel;
  logic [MAX_CAND-1:0] row_mask;
  logic [MAX_CAND-1:0] pick_mask;
  row_t pick_src;
  logic [SW-1:0] pick_idx;
  logic pick_found;
  logic pick_more;
  logic [ID_W-1:0] pick_id;
  logic [MAX_CAND-1:0] pick_bit;

  always_comb begin
    tbl_d = tbl_q;
    for (int h = 0; h <= MAX_HEIGHT; h++) begin
      for (int s = 0; s < MAX_CAND; s++) begin
        if (cfg_we && int'(cfg_height) == h
            && int'(cfg_slot) == s) begin
          tbl_d[h][s] = cfg_id;
        end
      end
    end
  end

  // Out-of-range heights match no row and read as all zero.
  always_comb begin
    row_sel = '0;
    for (int h = 0; h <= MAX_HEIGHT; h++) begin
      if (int'(height_q) == h) row_sel = tbl_q[h];
    end
    for (int s = 0; s < MAX_CAND; s++) begin
      row_mask[s] = |row_sel[s];
    end
  end

  assign pick_mask = (state_q == ST_LOOKUP) ? row_mask : rem_q;
  assign pick_src  = (state_q == ST_LOOKUP) ? row_sel : snap_q;

  rcs_pick_next #(
    .N(MAX_CAND)
  ) u_pick (
    .mask (pick_mask),
    .idx  (pick_idx),
    .found(pick_found),
    .more (pick_more)
  );

  always_comb begin
    pick_id  = '0;
    pick_bit = '0;
    for (int s = 0; s < MAX_CAND; s++) begin
      if (int'(pick_idx) == s) begin
        pick_id     = pick_src[s];
        pick_bit[s] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    height_d     = height_q;
    snap_d       = snap_q;
    rem_d        = rem_q;
    cand_valid_d = cand_valid_q;
    cand_id_d    = cand_id_q;
    cand_last_d  = cand_last_q;
    cand_none_d  = cand_none_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          height_d = req_height;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        snap_d       = row_sel;
        state_d      = ST_EMIT;
        cand_valid_d = 1'b1;
        if (pick_found) begin
          cand_id_d   = pick_id;
          cand_last_d = !pick_more;
          cand_none_d = 1'b0;
          rem_d       = row_mask & ~pick_bit;
        end else begin
          cand_id_d   = ID_W'(ID_NONE);
          cand_last_d = 1'b1;
          cand_none_d = 1'b1;
          rem_d       = '0;
        end
      end
      ST_EMIT: begin
        if (cand_valid_q && cand_ready) begin
          if (cand_last_q) begin
            state_d      = ST_IDLE;
            cand_valid_d = 1'b0;
            cand_id_d    = ID_W'(ID_NONE);
            cand_last_d  = 1'b0;
            cand_none_d  = 1'b0;
          end else begin
            cand_id_d   = pick_id;
            cand_last_d = !pick_more;
            rem_d       = rem_q & ~pick_bit;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      height_q     <= '0;
      snap_q       <= '0;
      rem_q        <= '0;
      cand_valid_q <= 1'b0;
      cand_id_q    <= '0;
      cand_last_q  <= 1'b0;
      cand_none_q  <= 1'b0;
      for (int h = 0; h <= MAX_HEIGHT; h++) begin
        tbl_q[h] <= '0;
      end
    end else begin
      state_q      <= state_d;
      height_q     <= height_d;
      snap_q       <= snap_d;
      rem_q        <= rem_d;
      cand_valid_q <= cand_valid_d;
      cand_id_q    <= cand_id_d;
      cand_last_q  <= cand_last_d;
      cand_none_q  <= cand_none_d;
      tbl_q        <= tbl_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign cand_valid = cand_valid_q;
  assign cand_id    = cand_id_q;
  assign cand_last  = cand_last_q;
  assign cand_none  = cand_none_q;

endmodule

// File: tb/tb_row_candidate_seq.sv
// Bench for row_candidate_seq: directed scenarios plus random traffic
// scored against a table model that lists nonzero slots per request.
module tb_row_candidate_seq;
  import rcs_pkg::*;

  localparam int H_W = 5;
  localparam int ID_W = 4;
  localparam int MAX_CAND = 3;
  localparam int MAX_HEIGHT = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [H_W-1:0] req_height = '0;
  logic cand_valid;
  logic cand_ready = 1'b0;
  logic [ID_W-1:0] cand_id;
  logic cand_last;
  logic cand_none;
  logic cfg_we = 1'b0;
  logic [H_W-1:0] cfg_height = '0;
  logic [SW-1:0] cfg_slot = '0;
  logic [ID_W-1:0] cfg_id = '0;
  logic busy;

  row_candidate_seq #(
    .H_W(H_W), .ID_W(ID_W),
    .MAX_CAND(MAX_CAND), .MAX_HEIGHT(MAX_HEIGHT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_height(req_height),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .cand_id(cand_id), .cand_last(cand_last),
    .cand_none(cand_none),
    .cfg_we(cfg_we), .cfg_height(cfg_height),
    .cfg_slot(cfg_slot), .cfg_id(cfg_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mtbl [MAX_HEIGHT+1][MAX_CAND];
  int exp_b [$];
  int got_b [$];
  int first_k, unstable, ready_viol;
  bit timed_out;
  int ready_mode = 0;
  int mid_k = -1;
  int mid_h, mid_s, mid_v;

  function automatic void model_write(input int h, input int s, input int v);
    if (h <= MAX_HEIGHT && s < MAX_CAND) mtbl[h][s] = v;
  endfunction

  function automatic void model_clear();
    for (int h = 0; h <= MAX_HEIGHT; h++)
      for (int s = 0; s < MAX_CAND; s++) mtbl[h][s] = 0;
  endfunction

  // Beat encoding: id*4 + last*2 + none.
  function automatic void model_expect(input int h);
    exp_b.delete();
    if (h <= MAX_HEIGHT)
      for (int s = 0; s < MAX_CAND; s++)
        if (mtbl[h][s] != 0) exp_b.push_back(mtbl[h][s] * 4);
    if (exp_b.size() == 0) exp_b.push_back(3);
    else exp_b[exp_b.size()-1] = exp_b[exp_b.size()-1] + 2;
  endfunction

  task automatic cfg_write(input int h, input int s, input int v);
    cfg_we = 1'b1;
    cfg_height = H_W'(h);
    cfg_slot = SW'(s);
    cfg_id = ID_W'(v);
    @(negedge clk);
    cfg_we = 1'b0;
    model_write(h, s, v);
  endtask

  task automatic run_req(input int h);
    bit done, hold;
    int hb, low_cnt;
    done = 0; hold = 0; hb = 0; low_cnt = 0;
    got_b.delete();
    first_k = -1; unstable = 0; ready_viol = 0; timed_out = 0;
    req_valid = 1'b1;
    req_height = H_W'(h);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (mid_k == k) begin
        cfg_we = 1'b1;
        cfg_height = H_W'(mid_h);
        cfg_slot = SW'(mid_s);
        cfg_id = ID_W'(mid_v);
        model_write(mid_h, mid_s, mid_v);
      end else begin
        cfg_we = 1'b0;
      end
      if (busy !== 1'b1 || req_ready !== 1'b0) ready_viol++;
      if (hold && (cand_valid !== 1'b1 ||
          int'({cand_id, cand_last, cand_none}) != hb)) unstable++;
      case (ready_mode)
        0: cand_ready = 1'b1;
        1: cand_ready = 1'($urandom_range(0, 1));
        default: cand_ready = (low_cnt >= 3);
      endcase
      if (cand_valid === 1'b1 && first_k < 0) first_k = k;
      hold = 0;
      if (cand_valid === 1'b1 && !cand_ready) begin
        hold = 1;
        hb = int'({cand_id, cand_last, cand_none});
        low_cnt++;
      end
      if (cand_valid === 1'b1 && cand_ready) begin
        got_b.push_back(int'({cand_id, cand_last, cand_none}));
        if (cand_last === 1'b1) done = 1;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    cand_ready = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({cand_valid, cand_last, cand_none, busy} !== 4'b0 || cand_id !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v%b l%b n%b b%b id%0d want all 0",
               cand_valid, cand_last, cand_none, busy, cand_id);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_basic();
    cfg_write(7, 0, 1);
    cfg_write(7, 1, 2);
    cfg_write(7, 2, 4);
    model_expect(7);
    ready_mode = 0;
    run_req(7);
    checks++;
    if (timed_out || got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL basic_count got %0d want %0d to=%0d", got_b.size(), exp_b.size(), timed_out);
    end else foreach (exp_b[i]) begin
      checks++;
      if (got_b[i] != exp_b[i]) begin
        errors++;
        $display("FAIL basic_beat%0d got %0d want %0d", i, got_b[i], exp_b[i]);
      end
    end
    checks++;
    if (first_k != 1) begin
      errors++;
      $display("FAIL basic_latency got k=%0d want 1", first_k);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL basic_busy_ready got %0d bad cycles want 0", ready_viol);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || cand_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle got rr%b b%b v%b want 1 0 0", req_ready, busy, cand_valid);
    end
  endtask

  task automatic test_single();
    cfg_write(12, 0, 9);
    model_expect(12);
    run_req(12);
    checks++;
    if (timed_out || got_b.size() != 1 || got_b[0] != exp_b[0]) begin
      errors++;
      $display("FAIL single_beat got n=%0d b0=%0d want n=1 b0=%0d",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : -1, exp_b[0]);
    end
  endtask

  task automatic test_out_of_range();
    cfg_write(20, 0, 6);
    model_expect(20);
    run_req(20);
    checks++;
    if (timed_out || got_b.size() != 1 || got_b[0] != 3) begin
      errors++;
      $display("FAIL oor_none got n=%0d b0=%0d want n=1 b0=3",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : -1);
    end
  endtask

  task automatic test_backpressure();
    cfg_write(4, 1, 8);
    cfg_write(4, 2, 10);
    model_expect(4);
    ready_mode = 2;
    run_req(4);
    ready_mode = 0;
    checks++;
    if (timed_out || got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", got_b.size(), exp_b.size());
    end else foreach (exp_b[i]) begin
      checks++;
      if (got_b[i] != exp_b[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %0d want %0d", i, got_b[i], exp_b[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes want 0", unstable);
    end
  endtask

  task automatic test_overwrite();
    model_expect(7);
    mid_k = 1; mid_h = 7; mid_s = 0; mid_v = 5;
    run_req(7);
    mid_k = -1;
    checks++;
    if (timed_out || got_b.size() != 3 || got_b[0] != 4) begin
      errors++;
      $display("FAIL ovw_inflight got n=%0d b0=%0d want n=3 b0=4",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : -1);
    end
    model_expect(7);
    run_req(7);
    checks++;
    if (timed_out || got_b.size() != 3 || got_b[0] != 20 || got_b != exp_b) begin
      errors++;
      $display("FAIL ovw_next got n=%0d b0=%0d want n=3 b0=20",
               got_b.size(), (got_b.size() > 0) ? got_b[0] : -1);
    end
    model_expect(12);
    mid_k = 0; mid_h = 12; mid_s = 0; mid_v = 3;
    run_req(12);
    mid_k = -1;
    checks++;
    if (timed_out || got_b.size() != 1 || got_b[0] != 38) begin
      errors++;
      $display("FAIL same_cycle_write got b0=%0d want 38",
               (got_b.size() > 0) ? got_b[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    req_valid = 1'b1;
    req_height = H_W'(7);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cand_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre got v%b want 1", cand_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cand_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_abort got v%b b%b want 0 0", cand_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      cand_ready = 1'b1;
      if (cand_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    cand_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_no_beats got %0d want 0", seen);
    end
    model_expect(7);
    run_req(7);
    checks++;
    if (timed_out || got_b.size() != 1 || got_b[0] != 3) begin
      errors++;
      $display("FAIL rmid_table_clear got b0=%0d want 3",
               (got_b.size() > 0) ? got_b[0] : -1);
    end
  endtask

  task automatic test_random();
    int h;
    for (int i = 0; i < 40; i++)
      cfg_write($urandom_range(0, 20), $urandom_range(0, 3), $urandom_range(0, 15));
    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      h = $urandom_range(0, 20);
      model_expect(h);
      mid_k = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1;
      mid_h = $urandom_range(0, 20);
      mid_s = $urandom_range(0, 3);
      mid_v = $urandom_range(0, 15);
      run_req(h);
      checks++;
      if (timed_out || got_b != exp_b || unstable != 0 || ready_viol != 0) begin
        errors++;
        $display("FAIL rand%0d h=%0d got n=%0d b0=%0d want n=%0d b0=%0d st=%0d rv=%0d",
                 r, h, got_b.size(), (got_b.size() > 0) ? got_b[0] : -1,
                 exp_b.size(), exp_b[0], unstable, ready_viol);
      end
    end
    mid_k = -1;
    ready_mode = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_out_of_range();
    test_backpressure();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_candidate_seq.md
ROW_CANDIDATE_SEQ -- requirements
Module: row_candidate_seq

Interface
REQ-001 Parameter H_W, default 5: height input width in bits.
REQ-002 Parameter ID_W, default 4: structure ID width; ID 0 means "no candidate".
REQ-003 Parameter MAX_CAND, default 3: candidate slots per height, range 1..8.
REQ-004 Parameter MAX_HEIGHT, default 16: largest height with a table entry; higher heights always return none.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  lookup request present.
REQ-008 req_ready  output  1  block accepts request this cycle.
REQ-009 req_height  input  H_W  program height to look up.
REQ-010 cand_valid  output  1  candidate beat present.
REQ-011 cand_ready  input  1  consumer accepts beat.
REQ-012 cand_id  output  ID_W  candidate structure ID.
REQ-013 cand_last  output  1  final beat of the current response.
REQ-014 cand_none  output  1  response has no candidates; cand_id is 0.
REQ-015 cfg_we  input  1  table write strobe.
REQ-016 cfg_height  input  H_W  table row to write.
REQ-017 cfg_slot  input  clog2(MAX_CAND) (min 1)  slot within row.
REQ-018 cfg_id  input  ID_W  value written.
REQ-019 busy  output  1  high in LOOKUP or EMIT.

Function
REQ-020 Table: (MAX_HEIGHT+1) rows x MAX_CAND slots x ID_W bits; cfg_we writes table[cfg_height][cfg_slot] <= cfg_id at the clock edge; writes with cfg_height > MAX_HEIGHT or cfg_slot >= MAX_CAND are ignored.
REQ-021 FSM states IDLE, LOOKUP, EMIT.
REQ-022 IDLE: req_ready=1; req_valid&req_ready latches req_height, goes to LOOKUP.
REQ-023 LOOKUP (one cycle): snapshots the selected row into a slot register and forms a nonzero-slot mask; height > MAX_HEIGHT gives an all-zero snapshot; goes to EMIT.
REQ-024 Latency: request accepted at edge T; cand_valid high from the cycle after edge T+1.
REQ-025 EMIT: emits nonzero slots in ascending slot order, one per accepted beat; zero slots skipped without bubble.
REQ-026 cand_last=1 on the beat carrying the highest nonzero slot.
REQ-027 All-zero snapshot: exactly one beat, cand_id=0, cand_none=1, cand_last=1.
REQ-028 cand_valid, cand_id, cand_last, cand_none registered; held stable while cand_valid=1 and cand_ready=0.
REQ-029 Beat with cand_last accepted: return to IDLE; req_ready high next cycle (no back-to-back overlap).
REQ-030 req_ready=0 in LOOKUP and EMIT; requests there are not accepted and not lost (producer holds them).
REQ-031 cfg writes during LOOKUP/EMIT update the table only; the in-flight response uses its snapshot.
REQ-032 cfg write and LOOKUP to the same row in one cycle: snapshot takes the pre-write value.

Reset
REQ-033 rst_n low: FSM to IDLE; cand_valid, cand_last, cand_none, busy = 0; cand_id = 0; req_ready = 1 after release.
REQ-034 rst_n low clears every table entry to 0.
REQ-035 Reset mid-response: current response aborted, no further beats after release.

Structure
REQ-036 Shared package rcs_pkg: FSM state enum, ID_NONE constant (0), default parameter constants.
REQ-037 One sub-module rcs_pick_next: combinational lowest-set-bit picker over the remaining-slot mask, returning slot index and "more remain" flag.

Verification
REQ-038 Program height 7 slots {1,2,4}; request 7, cand_ready=1 -> beats 1,2,4, last on 4, first valid two cycles after acceptance.
REQ-039 Program height 12 slots {9,0,0}; request 12 -> single beat 9, cand_last=1, cand_none=0.
REQ-040 Request height 20 (> MAX_HEIGHT) -> single beat id 0, cand_none=1, cand_last=1.
REQ-041 Height 4 slots {0,8,10}, cand_ready held low 3 cycles on first beat -> id 8 stable throughout, then 10 with last.
REQ-042 Overwrite slot 0 of row 7 with 5 during EMIT of height 7 -> stream remains 1,2,4; next request yields 5,2,4.
REQ-043 Assert rst_n low mid-EMIT -> cand_valid 0 immediately, table zero, request for 7 returns cand_none.
